fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read side of the byte FIFO: pops bytes from `fifo` whenever it is non-empty and transmits each as an asynchronous serial frame (start bit, 8 data bits LSB first, stop bit) on a single line. It sits directly on the FIFO read port (`rd_en`, `rd_data`, `fifo_empty`) and is the consumer the write-side producers feed into. One byte is in flight at a time; the FIFO provides all buffering.

## Interface
- `CLK_DIV`, 16: clock cycles per serial bit; legal range 2..65535.
- `DATA_W`, 8: FIFO word / serial data width.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `tx_en`  in  1: permits starting a new frame; sampled only in IDLE.
- `fifo_empty`  in  1: FIFO empty flag.
- `rd_data`  in  DATA_W: FIFO read data, valid the cycle after `rd_en` is sampled high.
- `rd_en`  out  1: FIFO pop strobe, one-cycle pulse.
- `txd`  out  1: serial line, idles high.
- `busy`  out  1: high from the pop cycle through the last stop-bit cycle.
- `frame_done`  out  1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE: `txd`=1. If `tx_en && !fifo_empty` -> POP.
- POP: `rd_en`=1 for exactly this cycle -> LOAD.
- LOAD: capture `rd_data` into shift register -> START.
- START: `txd`=0 for CLK_DIV cycles -> DATA.
- DATA: shift out DATA_W bits, LSB first, CLK_DIV cycles each; bit counter `$clog2(DATA_W)` wide -> PARITY (if compiled in) else STOP.
- STOP: `txd`=1 for CLK_DIV cycles; `frame_done` on the final cycle -> IDLE.
- `rd_en` is never asserted while `fifo_empty`=1 and never asserted outside POP.
- `tx_en` low mid-frame: current frame completes; no new pop.
- `fifo_empty` changes mid-frame: ignored until IDLE.
- Baud counter width `$clog2(CLK_DIV)`, counts 0..CLK_DIV-1, wraps at bit boundary.

## Timing
- Reset values: `rd_en`=0, `txd`=1, `busy`=0, `frame_done`=0; state IDLE, counters 0.
- Reset mid-frame: next cycle `txd`=1, byte discarded (already popped; not restored).
- Pop-to-start-bit latency: `rd_en` at cycle N, `txd` falls at cycle N+2.
- Frame length: (DATA_W+2)·CLK_DIV cycles, +CLK_DIV with parity.
- Back-to-back: after STOP, IDLE(1)+POP(1)+LOAD(1) gives 3 extra high cycles before the next start bit; legal as extended stop.
- `busy` rises in the POP cycle, falls the cycle after `frame_done`.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined: PARITY state inserted after DATA, one bit of even parity (XOR of data bits) held CLK_DIV cycles.
- Not defined: no PARITY state; STOP follows DATA directly.

## Structure
- Package `fifo_uart_pkg`: state enum, `DATA_W` default, frame-length constants.
- One sub-module: `uart_baud_gen` (CLK_DIV counter, `clear` input, `tick` output on last cycle of each bit).

## Test plan
- Reset: `rst`=1 two cycles with FIFO non-empty -> `txd`=1, `rd_en`=0, `busy`=0 throughout.
- Single byte, CLK_DIV=4, byte 0x35 -> one `rd_en` pulse; `txd` = 0,1,0,1,0,1,1,0,0,1, each held 4 cycles; `frame_done` at cycle 40 after start.
- Parity build, byte 0x35 -> parity bit 0 inserted before stop; frame 44 cycles; byte 0x07 -> parity bit 1.
- Back-to-back 0xA5,0x3C queued -> two frames, exactly two `rd_en` pulses, 3 idle-high cycles between stop end and second start.
- Empty FIFO / `tx_en`=0 with data queued -> `rd_en` never asserted, `txd`=1; `tx_en` dropped mid-frame -> frame completes, no further pop.
- `rst` in DATA state -> `txd`=1 next cycle, state IDLE, next queued byte sent as a clean full frame.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared state encodings and frame-length constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_POP    = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_DATA   = 3'd4;
   localparam logic [2:0] ST_PARITY = 3'd5;
   localparam logic [2:0] ST_STOP   = 3'd6;

   localparam int DATA_W_DEF       = 8;
   localparam int FRAME_BITS_NOPAR = DATA_W_DEF + 2;
   localparam int FRAME_BITS_PAR   = DATA_W_DEF + 3;

   function automatic int frame_cycles(input int clk_div, input bit parity_en);
      return (parity_en ? FRAME_BITS_PAR : FRAME_BITS_NOPAR) * clk_div;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1, tick on the last cycle of each bit.
// Held at zero while clear is high so every bit period starts aligned.
module uart_baud_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int              CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST) && !clear;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from the FIFO read port and sends it as a start/data/stop frame on txd.
// Latency: rd_en at cycle N, start bit at N+2; FIFO empty or tx_en low holds the line idle.
// Optional even parity bit after the data bits when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLK_DIV = 16,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_en,
   output logic              txd,
   output logic              busy,
   output logic              frame_done
);

   localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   logic [2:0]        state;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     bit_cnt;
   logic              tick;
   logic              baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              parity_bit;
`endif

   // The bit timer only runs while a frame is on the line.
   assign baud_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (tx_en && !fifo_empty) state <= ST_POP;
            end
            ST_POP: state <= ST_LOAD;
            ST_LOAD: begin
               shreg   <= rd_data;
               bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_bit <= ^rd_data;
`endif
               state   <= ST_START;
            end
            ST_START: begin
               if (tick) state <= ST_DATA;
            end
            ST_DATA: begin
               if (tick) begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) state <= ST_STOP;
            end
`endif
            ST_STOP: begin
               if (tick) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      txd = 1'b1;
      case (state)
         ST_START: txd = 1'b0;
         ST_DATA:  txd = shreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: txd = parity_bit;
`endif
         default:  txd = 1'b1;
      endcase
   end

   assign rd_en      = (state == ST_POP);
   assign busy       = (state != ST_IDLE);
   assign frame_done = (state == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a FIFO model and an expected-byte scoreboard.
module tb_fifo_uart_tx;

   localparam int CLK_DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int TOTAL = NBITS * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_en = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] rd_data = 8'h00;
   logic       rd_en, txd, busy, frame_done;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int viol = 0;
   int last_rd_cyc = 0;
   int last_done_cyc = 0;

   fifo_uart_tx #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty),
      .rd_data    (rd_data),
      .rd_en      (rd_en),
      .txd        (txd),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rd_en === 1'b1) begin
         rd_cnt++;
         last_rd_cyc = cyc;
         if (fifo_empty !== 1'b0) viol++;
      end
   end

   // FIFO read port: data for a pop becomes visible before the following cycle.
   always @(negedge clk) begin
      if (rd_en === 1'b1 && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic wait_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_txd", txd, 1);
         check("idle_busy", busy, 0);
      end
   endtask

   task automatic check_frame(input int gap, input int drop_at);
      logic [7:0] exp_b;
      logic [7:0] got;
      logic       exp_txd;
      int         t;
      int         bitno;
      got = 8'h00;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (txd !== 1'b0 && t < 400);
      check("start_seen", txd, 0);
      if (exp_q.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
         exp_b = 8'h00;
      end else begin
         exp_b = exp_q.pop_front();
      end
      check("pop_to_start", cyc - last_rd_cyc, 2);
      if (gap > 0) check("b2b_gap", cyc - last_done_cyc, gap);
      for (int k = 1; k <= TOTAL; k++) begin
         if (k > 1) @(negedge clk);
         bitno = (k - 1) / CLK_DIV;
         if (bitno == 0) exp_txd = 1'b0;
         else if (bitno <= 8) exp_txd = exp_b[bitno-1];
`ifdef FIFO_UART_TX_PARITY_EN
         else if (bitno == 9) exp_txd = ^exp_b;
`endif
         else exp_txd = 1'b1;
         check($sformatf("txd_k%0d", k), txd, exp_txd);
         check($sformatf("frame_done_k%0d", k), frame_done, (k == TOTAL));
         check($sformatf("busy_k%0d", k), busy, 1);
         if (bitno >= 1 && bitno <= 8 && ((k - 1) % CLK_DIV) == CLK_DIV / 2) got[bitno-1] = txd;
         if (k == TOTAL) last_done_cyc = cyc;
         if (k == drop_at) tx_en = 1'b0;
      end
      @(negedge clk);
      check("post_busy", busy, 0);
      check("post_frame_done", frame_done, 0);
      check("post_txd", txd, 1);
      check("rx_byte", got, exp_b);
   endtask

   initial begin
      int base;
      int t;
      // Reset with data waiting in the FIFO.
      push(8'h35);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_txd", txd, 1);
         check("rst_rd_en", rd_en, 0);
         check("rst_busy", busy, 0);
         check("rst_frame_done", frame_done, 0);
      end
      rst = 1'b0;

      base = rd_cnt;
      check_frame(0, 0);
      check("single_pops", rd_cnt - base, 1);

      push(8'h07);
      check_frame(0, 0);

      // Back-to-back bytes.
      base = rd_cnt;
      push(8'hA5);
      push(8'h3C);
      check_frame(0, 0);
      check_frame(4, 0);
      check("b2b_pops", rd_cnt - base, 2);

      // Empty FIFO, then data held back by tx_en.
      base = rd_cnt;
      wait_idle(12);
      tx_en = 1'b0;
      push(8'h5A);
      wait_idle(20);
      check("tx_en_low_pops", rd_cnt - base, 0);
      tx_en = 1'b1;
      check_frame(0, 0);

      // tx_en dropped mid-frame: current frame finishes, nothing further popped.
      base = rd_cnt;
      push(8'hC3);
      push(8'h99);
      check_frame(0, 10);
      wait_idle(20);
      check("drop_pops", rd_cnt - base, 1);
      check("drop_fifo_left", fifo_q.size(), 1);
      tx_en = 1'b1;
      check_frame(0, 0);

      // Reset while shifting data bits.
      push(8'hF0);
      push(8'h6B);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (txd !== 1'b0 && t < 400);
      check("abort_start_seen", txd, 0);
      void'(exp_q.pop_front());
      repeat (CLK_DIV + 6) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_txd", txd, 1);
      check("abort_busy", busy, 0);
      check("abort_rd_en", rd_en, 0);
      rst = 1'b0;
      check_frame(0, 0);

      wait_idle(5);
      check("rd_en_while_empty", viol, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
